mant_mul_seq: RTL and testbench

MANT_MUL_SEQ -- requirements
Module: mant_mul_seq

---
 rtl/fmul32_pkg.sv | 21 ++
 rtl/lzc_count.sv | 28 ++
 rtl/mant_mul_seq.sv | 122 ++++++++++++
 tb/tb_mant_mul_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fmul32_pkg.sv
// ----------------------------------------------------------------------------
// fmul32_pkg : shared FMUL32 types and defaults (mantissa width, FSM states)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fmul32_pkg;

  localparam int MANT_W_DEFAULT = 24;
  localparam int LZC_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/lzc_count.sv
// ----------------------------------------------------------------------------
// lzc_count : combinational leading-zero count from the MSB; all-zero -> IN_W
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lzc_count
  import fmul32_pkg::*;
#(
  parameter int IN_W = 48
) (
  input  logic [IN_W-1:0]  value,
  output logic [LZC_W-1:0] count
);

  // Scan upward so the highest set bit is the last one to assign.
  always_comb begin
    count = LZC_W'(IN_W);
    for (int i = 0; i < IN_W; i++) begin
      if (value[i]) begin
        count = LZC_W'(IN_W - 1 - i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mant_mul_seq.sv
// ----------------------------------------------------------------------------
// mant_mul_seq : sequential radix-2 shift-add mantissa multiplier with LZC
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mant_mul_seq
  import fmul32_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MANT_W-1:0]   mant_a,
  input  logic [MANT_W-1:0]   mant_b,
  output logic                busy,
  output logic                done,
  output logic [2*MANT_W-1:0] product,
  output logic [LZC_W-1:0]    leading_zero_num,
  output logic                exp_incr
);

  localparam int PROD_W = 2 * MANT_W;
  localparam int CNT_W  = $clog2(MANT_W + 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] product_q, product_d;
  logic [LZC_W-1:0]  lzc_q, lzc_d;
  logic              exp_incr_q, exp_incr_d;
  logic [LZC_W-1:0]  acc_lzc;

  lzc_count #(
    .IN_W (PROD_W)
  ) u_lzc (
    .value (acc_q),
    .count (acc_lzc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      product_q  <= '0;
      lzc_q      <= '0;
      exp_incr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      product_q  <= product_d;
      lzc_q      <= lzc_d;
      exp_incr_q <= exp_incr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    product_d  = product_q;
    lzc_d      = lzc_q;
    exp_incr_d = exp_incr_q;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          mcand_d  = {{MANT_W{1'b0}}, mant_a};
          mplier_d = mant_b;
          acc_d    = '0;
          cnt_d    = CNT_W'(MANT_W - 1);
          state_d  = ST_MUL;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_MUL: begin
        busy = 1'b1;
        // Full-width add: the carry out of each partial sum stays in acc.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == '0) begin
          state_d = ST_NORM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_NORM: begin
        busy       = 1'b1;
        product_d  = acc_q;
        lzc_d      = acc_lzc;
        exp_incr_d = acc_q[PROD_W-1];
        state_d    = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign product          = product_q;
  assign leading_zero_num = lzc_q;
  assign exp_incr         = exp_incr_q;

endmodule

`default_nettype wire

// File: tb/tb_mant_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_mant_mul_seq : self-checking bench for mant_mul_seq against a math model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mant_mul_seq;

  localparam int W  = 24;
  localparam int PW = 48;
  // Edges counted with the start-sampling edge as edge 1.
  localparam int DONE_EDGE = W + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  mant_a = '0;
  logic [W-1:0]  mant_b = '0;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;
  logic [7:0]    leading_zero_num;
  logic          exp_incr;

  int checks = 0;
  int errors = 0;

  mant_mul_seq #(.MANT_W(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .mant_a           (mant_a),
    .mant_b           (mant_b),
    .busy             (busy),
    .done             (done),
    .product          (product),
    .leading_zero_num (leading_zero_num),
    .exp_incr         (exp_incr)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [PW-1:0] aw, bw;
    aw = PW'(a);
    bw = PW'(b);
    return aw * bw;
  endfunction

  function automatic int ref_lzc(input logic [PW-1:0] p);
    int n = 0;
    while (n < PW && p[PW-1-n] == 1'b0) n++;
    return n;
  endfunction

  // Waits for done; edge_n is the done edge counted from the sampling edge (=1).
  task automatic wait_done(output int edge_n);
    edge_n = 1;
    while (done !== 1'b1 && edge_n < 80) begin
      @(negedge clk);
      edge_n++;
    end
  endtask

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, output int edge_n);
    @(negedge clk);
    mant_a = a;
    mant_b = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(edge_n);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input int edge_n);
    logic [PW-1:0] ep;
    ep = ref_prod(a, b);
    checks += 4;
    if (edge_n !== DONE_EDGE) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, edge_n, DONE_EDGE);
    end
    if (product !== ep) begin
      errors++;
      $display("FAIL %s product: got %h want %h", name, product, ep);
    end
    if (int'(leading_zero_num) !== ref_lzc(ep)) begin
      errors++;
      $display("FAIL %s lzc: got %0d want %0d", name, leading_zero_num, ref_lzc(ep));
    end
    if (exp_incr !== ep[PW-1]) begin
      errors++;
      $display("FAIL %s exp_incr: got %b want %b", name, exp_incr, ep[PW-1]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, product, leading_zero_num, exp_incr} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b prod=%h lzc=%0d ei=%b want all 0",
               busy, done, product, leading_zero_num, exp_incr);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{24'h800000, 24'hC00000, 24'h000000, 24'h000001};
    logic [W-1:0] tb [4] = '{24'h800000, 24'hC00000, 24'hFFFFFF, 24'h800000};
    logic [PW-1:0] sp [4] = '{48'h400000000000, 48'h900000000000, 48'h0, 48'h000000800000};
    int           sl [4] = '{1, 0, 48, 24};
    int e;
    for (int i = 0; i < 4; i++) begin
      do_mul(ta[i], tb[i], e);
      check_result($sformatf("dir%0d", i), ta[i], tb[i], e);
      checks += 3;
      if (product !== sp[i] || int'(leading_zero_num) !== sl[i]) begin
        errors++;
        $display("FAIL dir%0d const: got %h/%0d want %h/%0d", i, product, leading_zero_num, sp[i], sl[i]);
      end
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d busy_in_done: got %b want 0", i, busy);
      end
      @(negedge clk);
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d done_pulse_width: got %b want 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int e;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      if (i % 5 == 0) a[W-1] = 1'b1;
      do_mul(a, b, e);
      check_result($sformatf("rand%0d", i), a, b, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1 = 24'hA5A5A5, b1 = 24'h3C3C3C;
    logic [W-1:0] a2 = 24'hFFFFFF, b2 = 24'hFFFFFF;
    int e;
    @(negedge clk);
    mant_a = a1; mant_b = b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = 1;
    repeat (8) begin @(negedge clk); e++; end
    // Pulse start on edge 10 with other operands: must be ignored.
    mant_a = 24'h123456; mant_b = 24'h654321; start = 1'b1;
    @(negedge clk); e++;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b busy_mid: got %b want 1", busy);
    end
    repeat (5) begin @(negedge clk); e++; end
    mant_a = a2; mant_b = b2; start = 1'b1;
    while (done !== 1'b1 && e < 80) begin @(negedge clk); e++; end
    check_result("b2b_first", a1, b1, e);
    @(negedge clk);
    start = 1'b0;
    wait_done(e);
    check_result("b2b_second", a2, b2, e);
  endtask

  task automatic test_reset_mid();
    int e;
    int seen = 0;
    @(negedge clk);
    mant_a = 24'hFFF000; mant_b = 24'h0FFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, product, leading_zero_num, exp_incr} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b done=%b prod=%h lzc=%0d ei=%b want all 0",
               busy, done, product, leading_zero_num, exp_incr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_done: activity cycles %0d want 0", seen);
    end
    do_mul(24'hFFF000, 24'h0FFFFF, e);
    check_result("midrst_restart", 24'hFFF000, 24'h0FFFFF, e);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
